// File: rtl/iob_eth_host_ctrl_if.sv
// CPU-side register bus of the Ethernet core: valid/ready request with byte
// strobes, where wstrb == 0 marks a read.
interface iob_eth_host_ctrl_if #(
  parameter int ADDR_W = 12
) ();
  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic [31:0]       m_rdata;
  logic              m_ready;

  modport master (output m_valid, m_addr, m_wdata, m_wstrb, input m_rdata, m_ready);
  modport slave  (input m_valid, m_addr, m_wdata, m_wstrb, output m_rdata, m_ready);
endinterface

// File: rtl/iob_eth_host_ctrl.sv
// Hardware host for the Ethernet core: streams TX bytes into the core buffer and
// issues SEND, polls STATUS for received frames and streams the RX buffer out.
module iob_eth_host_ctrl #(
  parameter int                ADDR_W         = 12,
  parameter logic [ADDR_W-1:0] ADDR_STATUS    = 12'h000,
  parameter logic [ADDR_W-1:0] ADDR_SEND      = 12'h001,
  parameter logic [ADDR_W-1:0] ADDR_RCVACK    = 12'h002,
  parameter logic [ADDR_W-1:0] ADDR_TX_NBYTES = 12'h004,
  parameter logic [ADDR_W-1:0] ADDR_RX_NBYTES = 12'h005,
  parameter logic [ADDR_W-1:0] DATA_BASE      = 12'h800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] cfg_rx_nbytes,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_last,
  input  logic        rx_ready,
  output logic        tx_ovf,
  iob_eth_host_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_TX_POLL, S_TX_DATA, S_TX_NBYTES, S_TX_SEND,
    S_RX_POLL, S_RX_DATA, S_RX_ACK
  } state_t;

  state_t            state;
  logic [10:0]       idx;
  logic [10:0]       cfg_lat;
  logic              ovf;
  logic              last_seen;

  logic              req_go;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              start;
  logic              done;
  logic              idx_full;
  logic [10:0]       cfg_eff;
  logic              unused_rdata;

  assign done         = bus.m_valid & bus.m_ready;
  assign start        = ~bus.m_valid & req_go;
  assign idx_full     = &idx;
  assign cfg_eff      = (cfg_rx_nbytes == 11'd0) ? 11'd46 : cfg_rx_nbytes;
  assign unused_rdata = ^bus.m_rdata[31:8];

  // Access each state wants to issue; it is launched only when the bus is idle,
  // and since completion drops m_valid first, a one-cycle gap is guaranteed.
  always_comb begin
    req_go    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = 4'hF;
    case (state)
      S_INIT: begin
        req_go    = 1'b1;
        req_addr  = ADDR_RX_NBYTES;
        req_wdata = {21'd0, cfg_eff};
      end
      S_TX_POLL, S_RX_POLL: begin
        req_go    = 1'b1;
        req_addr  = ADDR_STATUS;
        req_wstrb = 4'h0;
      end
      S_TX_DATA: begin
        req_go    = tx_ready & tx_valid & ~idx_full;
        req_addr  = DATA_BASE + ADDR_W'(idx);
        req_wdata = {24'd0, tx_data};
      end
      S_TX_NBYTES: begin
        req_go    = 1'b1;
        req_addr  = ADDR_TX_NBYTES;
        req_wdata = {21'd0, idx};
      end
      S_TX_SEND: begin
        req_go    = 1'b1;
        req_addr  = ADDR_SEND;
        req_wdata = 32'd1;
      end
      S_RX_DATA: begin
        req_go    = ~rx_valid;
        req_addr  = DATA_BASE + ADDR_W'(idx);
        req_wstrb = 4'h0;
      end
      S_RX_ACK: begin
        req_go    = 1'b1;
        req_addr  = ADDR_RCVACK;
        req_wdata = 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_INIT;
      idx         <= '0;
      cfg_lat     <= '0;
      ovf         <= 1'b0;
      last_seen   <= 1'b0;
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_last     <= 1'b0;
      tx_ovf      <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_wstrb <= '0;
    end else begin
      tx_ovf <= 1'b0;
      if (start) begin
        bus.m_valid <= 1'b1;
        bus.m_addr  <= req_addr;
        bus.m_wdata <= req_wdata;
        bus.m_wstrb <= req_wstrb;
      end else if (done) begin
        bus.m_valid <= 1'b0;
      end

      case (state)
        S_INIT: begin
          if (start) cfg_lat <= cfg_eff;
          if (done) state <= S_IDLE;
        end
        S_IDLE: state <= tx_valid ? S_TX_POLL : S_RX_POLL;
        S_TX_POLL: if (done && bus.m_rdata[0]) state <= S_TX_DATA;
        S_TX_DATA: begin
          if (done) begin
            if (last_seen) state <= S_TX_NBYTES;
          end else if (!bus.m_valid) begin
            if (tx_ready && tx_valid) begin
              tx_ready  <= 1'b0;
              last_seen <= tx_last;
              // Bytes beyond the buffer are accepted and discarded.
              if (idx_full) begin
                ovf <= 1'b1;
                if (tx_last) state <= S_TX_NBYTES;
              end else begin
                idx <= idx + 11'd1;
              end
            end else if (!last_seen) begin
              tx_ready <= 1'b1;
            end
          end
        end
        S_TX_NBYTES: if (done) state <= S_TX_SEND;
        S_TX_SEND: begin
          if (start) tx_ovf <= ovf;
          if (done) begin
            idx       <= '0;
            ovf       <= 1'b0;
            last_seen <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_RX_POLL: if (done) state <= bus.m_rdata[1] ? S_RX_DATA : S_IDLE;
        S_RX_DATA: begin
          if (done) begin
            rx_data  <= bus.m_rdata[7:0];
            rx_valid <= 1'b1;
            rx_last  <= (idx == cfg_lat - 11'd1);
          end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            rx_last  <= 1'b0;
            if (rx_last) begin
              idx   <= '0;
              state <= S_RX_ACK;
            end else begin
              idx <= idx + 11'd1;
            end
          end
        end
        S_RX_ACK: begin
          if (done) begin
            idx   <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_eth_host_ctrl.sv
// Directed bench for iob_eth_host_ctrl with a small Ethernet-core register model
// (ready one cycle after valid, scripted STATUS, RX buffer contents).
module tb_iob_eth_host_ctrl;

  localparam logic [11:0] A_STATUS = 12'h000;
  localparam logic [11:0] A_SEND   = 12'h001;
  localparam logic [11:0] A_RCVACK = 12'h002;
  localparam logic [11:0] A_TXN    = 12'h004;
  localparam logic [11:0] A_RXN    = 12'h005;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] cfg_rx_nbytes;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_last;
  logic        rx_ready;
  logic        tx_ovf;

  iob_eth_host_ctrl_if #(.ADDR_W(12)) bus ();

  iob_eth_host_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_rx_nbytes (cfg_rx_nbytes),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_last       (tx_last),
    .tx_ready      (tx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_last       (rx_last),
    .rx_ready      (rx_ready),
    .tx_ovf        (tx_ovf),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Core model: counters written only here, scripting knobs only by the stimulus.
  int         stat_cnt, ack_cnt, buf_rd_cnt;
  int         stat_base, tx_zeros, rx_req;
  logic [7:0] rxbuf [0:2047];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.m_ready <= 1'b0;
      stat_cnt    <= 0;
      ack_cnt     <= 0;
      buf_rd_cnt  <= 0;
    end else begin
      bus.m_ready <= bus.m_valid;
      if (bus.m_valid && bus.m_ready) begin
        if (bus.m_wstrb == 4'h0 && bus.m_addr == A_STATUS) stat_cnt <= stat_cnt + 1;
        if (bus.m_wstrb == 4'h0 && bus.m_addr[11]) buf_rd_cnt <= buf_rd_cnt + 1;
        if (bus.m_wstrb != 4'h0 && bus.m_addr == A_RCVACK) ack_cnt <= ack_cnt + 1;
      end
    end
  end

  always_comb begin
    bus.m_rdata = '0;
    if (bus.m_addr == A_STATUS)
      bus.m_rdata = {30'd0, ack_cnt < rx_req, stat_cnt >= stat_base + tx_zeros};
    else if (bus.m_addr[11])
      bus.m_rdata = {24'd0, rxbuf[bus.m_addr[10:0]]};
  end

  // Bus monitor: transaction log plus protocol and overflow-pulse bookkeeping.
  txn_t log_q[$];
  txn_t cur, pt;
  logic pv, pr;
  int   proto_err = 0;
  int   ovf_cnt = 0;
  int   ovf_bad = 0;

  assign cur = {bus.m_addr, bus.m_wdata, bus.m_wstrb};

  always @(negedge clk) begin
    if (!rst) begin
      pv <= 1'b0;
      pr <= 1'b0;
    end else begin
      proto_err <= proto_err + int'(pv && pr && bus.m_valid)
                             + int'(pv && !pr && (!bus.m_valid || cur != pt))
                             + int'(tx_ready && bus.m_valid);
      ovf_cnt <= ovf_cnt + int'(tx_ovf);
      ovf_bad <= ovf_bad + int'(tx_ovf && !(bus.m_valid && bus.m_addr == A_SEND && bus.m_wstrb == 4'hF));
      if (bus.m_valid && bus.m_ready) log_q.push_back(cur);
      pv <= bus.m_valid;
      pr <= bus.m_ready;
      pt <= cur;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int lp = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_write(output txn_t e);
    int t;
    t = 0;
    e = '0;
    forever begin
      while (lp >= log_q.size() && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (lp >= log_q.size()) begin
        check("txn_timeout", 64'd0, 64'd1);
        return;
      end
      e = log_q[lp];
      lp++;
      if (e.wstrb != 4'h0) return;
    end
  endtask

  task automatic expect_write(input string tag, input logic [11:0] a, input logic [31:0] d);
    txn_t e, w;
    next_write(e);
    w = {a, d, 4'hF};
    check(tag, 64'(e), 64'(w));
  endtask

  task automatic wait_status_done();
    int t;
    t = 0;
    while (!(bus.m_valid && bus.m_ready && bus.m_wstrb == 4'h0 && bus.m_addr == A_STATUS) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("status_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    t = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    tx_last  = last;
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) check("tx_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_rx [4];
    txn_t e, w;
    int good;

    rst = 1'b0; cfg_rx_nbytes = 11'd64;
    tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; rx_ready = 1'b0;
    stat_base = 0; tx_zeros = 0; rx_req = 0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_outputs", 64'({tx_ready, rx_valid, rx_data, rx_last, tx_ovf, bus.m_wstrb}), 64'd0);
    check("rst_addr_wdata", 64'({bus.m_addr, bus.m_wdata}), 64'd0);
    rst = 1'b1;
    expect_write("init_cfg64", A_RXN, 32'd64);

    // Three-byte frame
    wait_status_done();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    tx_valid = 1'b0; tx_last = 1'b0;
    expect_write("tx_byte0", 12'h800, 32'h0000_00AA);
    expect_write("tx_byte1", 12'h801, 32'h0000_00BB);
    expect_write("tx_byte2", 12'h802, 32'h0000_00CC);
    expect_write("tx_nbytes3", A_TXN, 32'd3);
    expect_write("tx_send", A_SEND, 32'd1);

    // Core not ready for 5 polls
    wait_status_done();
    stat_base = stat_cnt; tx_zeros = 5;
    tx_valid = 1'b1; tx_data = 8'hDD; tx_last = 1'b1;
    begin
      int t;
      t = 0;
      while (!tx_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
    end
    check("tx_poll_reads", 64'(stat_cnt - stat_base), 64'd6);
    send_byte(8'hDD, 1'b1);
    tx_valid = 1'b0; tx_last = 1'b0; tx_zeros = 0;
    expect_write("tx1_byte0", 12'h800, 32'h0000_00DD);
    expect_write("tx1_nbytes", A_TXN, 32'd1);
    expect_write("tx1_send", A_SEND, 32'd1);

    // Abort mid-access, restart with cfg=4 and a pending RX frame
    begin
      int t;
      t = 0;
      while (!bus.m_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    rst = 1'b0;
    #1;
    check("async_abort_m_valid", 64'(bus.m_valid), 64'd0);
    cfg_rx_nbytes = 11'd4; rx_req = 1; stat_base = 0;
    rxbuf[0] = 8'h11; rxbuf[1] = 8'h22; rxbuf[2] = 8'h33; rxbuf[3] = 8'h44;
    exp_rx[0] = 8'h11; exp_rx[1] = 8'h22; exp_rx[2] = 8'h33; exp_rx[3] = 8'h44;
    lp = log_q.size();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_write("init_cfg4", A_RXN, 32'd4);

    for (int i = 0; i < 4; i++) begin
      int t;
      t = 0;
      while (!rx_valid && t < 500) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("rx_data%0d", i), 64'(rx_data), 64'(exp_rx[i]));
      check($sformatf("rx_last%0d", i), 64'(rx_last), 64'(i == 3));
      if (i == 2) begin
        repeat (10) @(negedge clk);
        check("rx_stall_reads", 64'(buf_rd_cnt), 64'd3);
        check("rx_stall_hold", 64'({rx_valid, rx_data}), 64'({1'b1, 8'h33}));
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    expect_write("rx_ack", A_RCVACK, 32'd1);
    check("rx_total_reads", 64'(buf_rd_cnt), 64'd4);

    // 2050-byte frame: the last three bytes are dropped
    wait_status_done();
    for (int k = 0; k < 2050; k++) send_byte(8'(k), k == 2049);
    tx_valid = 1'b0; tx_last = 1'b0;
    good = 0;
    for (int k = 0; k < 2047; k++) begin
      next_write(e);
      w.addr  = 12'h800 + 12'(k);
      w.wdata = {24'd0, 8'(k)};
      w.wstrb = 4'hF;
      if (e == w) good++;
    end
    check("ovf_buf_writes", 64'(good), 64'd2047);
    expect_write("ovf_nbytes", A_TXN, 32'd2047);
    expect_write("ovf_send", A_SEND, 32'd1);
    repeat (5) @(negedge clk);
    check("ovf_pulse_count", 64'(ovf_cnt), 64'd1);
    check("ovf_pulse_at_send", 64'(ovf_bad), 64'd0);
    check("bus_protocol", 64'(proto_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
